// File: rtl/t_state_sequencer_pkg.sv
// Shared timing definitions for the T-state sequencer and the control decoder:
// one-hot T states, opcode constants and interrupt source codes.
package timingDefs;

  typedef enum logic [6:0] {
    Tone   = 7'b000_0001,
    Ttwo   = 7'b000_0010,
    Tthree = 7'b000_0100,
    Tfour  = 7'b000_1000,
    Tfive  = 7'b001_0000,
    Tsix   = 7'b010_0000,
    Tseven = 7'b100_0000
  } tstate_e;

  localparam logic [7:0] OP_BRK = 8'h00;
  localparam logic [7:0] OP_NOP = 8'hEA;

  localparam logic [2:0] INT_RESET = 3'b100;
  localparam logic [2:0] INT_NMI   = 3'b010;
  localparam logic [2:0] INT_IRQ   = 3'b001;
  localparam logic [2:0] INT_NONE  = 3'b000;

endpackage

// File: rtl/t_state_sequencer_if.sv
// Bundle between the T-state sequencer (slave) and the decoder/CPU side (master).
// Single-cycle: the master's inputs are sampled on each phi2 edge, and the state outputs come from registers.
interface t_state_sequencer_if;
  logic       rdy;
  logic [7:0] dataIn;
  logic       endInstr;
  logic       nmi_n;
  logic       irq_n;
  logic       iFlag;
  logic [6:0] T;
  logic [7:0] OP;
  logic [7:0] prevOP;
  logic [2:0] activeInt;
  logic       sync;
  logic       seqErr;

  modport master (
    output rdy, dataIn, endInstr, nmi_n, irq_n, iFlag,
    input  T, OP, prevOP, activeInt, sync, seqErr
  );

  modport slave (
    input  rdy, dataIn, endInstr, nmi_n, irq_n, iFlag,
    output T, OP, prevOP, activeInt, sync, seqErr
  );
endinterface

// File: rtl/t_state_sequencer_int_latch.sv
// Interrupt latch: NMI edge detect, reset/NMI pending bits, IRQ gating and priority encode.
// take_code_o is combinational; a source's pending bit clears on the edge where consume_i takes it.
module int_latch
  import timingDefs::*;
(
  input  logic       phi2_i,
  input  logic       rst_i,
  input  logic       nmi_n_i,
  input  logic       irq_n_i,
  input  logic       iflag_i,
  input  logic       consume_i,
  output logic [2:0] take_code_o
);

  logic reset_pend_q, reset_pend_d;
  logic nmi_pend_q, nmi_pend_d;
  logic nmi_prev_q;
  logic nmi_edge;
  logic irq_req;

  assign nmi_edge = nmi_prev_q & ~nmi_n_i;
  assign irq_req  = ~irq_n_i & ~iflag_i;

  always_comb begin
    take_code_o = INT_NONE;
    if (reset_pend_q) begin
      take_code_o = INT_RESET;
    end else if (nmi_pend_q | nmi_edge) begin
      take_code_o = INT_NMI;
    end else if (irq_req) begin
      take_code_o = INT_IRQ;
    end
  end

  // An NMI edge arriving in the consuming cycle is absorbed, not left pending.
  always_comb begin
    reset_pend_d = reset_pend_q & ~(consume_i && take_code_o == INT_RESET);
    nmi_pend_d   = (nmi_pend_q | nmi_edge) & ~(consume_i && take_code_o == INT_NMI);
  end

  always_ff @(posedge phi2_i) begin
    if (rst_i) begin
      reset_pend_q <= 1'b1;
      nmi_pend_q   <= 1'b0;
      nmi_prev_q   <= 1'b1;
    end else begin
      reset_pend_q <= reset_pend_d;
      nmi_pend_q   <= nmi_pend_d;
      nmi_prev_q   <= nmi_n_i;
    end
  end

endmodule

// File: rtl/t_state_sequencer.sv
// One-hot T-state sequencer and opcode register, injecting BRK for taken interrupts.
// All state advances only when rdy is high; rst overrides everything.
module t_state_sequencer
  import timingDefs::*;
(
  input  logic               phi2,
  input  logic               rst,
  t_state_sequencer_if.slave bus
);

  tstate_e    t_q, t_d;
  logic [7:0] op_q, op_d;
  logic [7:0] prev_op_q, prev_op_d;
  logic [2:0] act_q, act_d;
  logic       seq_err_q, seq_err_d;
  logic [2:0] take_code;
  logic       consume;

  assign consume = bus.rdy && (t_q == Tone);

  int_latch u_int_latch (
    .phi2_i      (phi2),
    .rst_i       (rst),
    .nmi_n_i     (bus.nmi_n),
    .irq_n_i     (bus.irq_n),
    .iflag_i     (bus.iFlag),
    .consume_i   (consume),
    .take_code_o (take_code)
  );

  always_comb begin
    t_d       = t_q;
    op_d      = op_q;
    prev_op_d = prev_op_q;
    act_d     = act_q;
    seq_err_d = seq_err_q;
    if (bus.rdy) begin
      unique case (t_q)
        Tone: begin
          prev_op_d = op_q;
          if (take_code != INT_NONE) begin
            op_d  = OP_BRK;
            act_d = take_code;
          end else begin
            op_d  = bus.dataIn;
            act_d = INT_NONE;
          end
          t_d = Ttwo;
        end
        Ttwo, Tthree, Tfour, Tfive, Tsix: begin
          t_d = bus.endInstr ? Tone : tstate_e'(t_q << 1);
        end
        Tseven: begin
          t_d = Tone;
          if (!bus.endInstr) seq_err_d = 1'b1;
        end
        default: t_d = Tone;
      endcase
    end
  end

  always_ff @(posedge phi2) begin
    if (rst) begin
      t_q       <= Tone;
      op_q      <= OP_NOP;
      prev_op_q <= OP_NOP;
      act_q     <= INT_NONE;
      seq_err_q <= 1'b0;
    end else begin
      t_q       <= t_d;
      op_q      <= op_d;
      prev_op_q <= prev_op_d;
      act_q     <= act_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign bus.T         = t_q;
  assign bus.OP        = op_q;
  assign bus.prevOP    = prev_op_q;
  assign bus.activeInt = act_q;
  assign bus.sync      = t_q[0];
  assign bus.seqErr    = seq_err_q;

endmodule

// File: tb/tb_t_state_sequencer.sv
// Directed vector bench for t_state_sequencer: a cycle table plus a hand-written seqErr sequence.
module tb_t_state_sequencer;

  logic phi2 = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  t_state_sequencer_if bus ();

  t_state_sequencer dut (
    .phi2 (phi2),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 phi2 = ~phi2;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [7:0] din;
    logic       endi;
    logic       nmi_n;
    logic       irq_n;
    logic       iflag;
    logic [6:0] e_t;
    logic [7:0] e_op;
    logic [7:0] e_prev;
    logic [2:0] e_act;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic rd, input logic [7:0] din, input logic endi,
                     input logic nmi_n, input logic irq_n, input logic iflag,
                     input logic [6:0] e_t, input logic [7:0] e_op, input logic [7:0] e_prev,
                     input logic [2:0] e_act);
    vec_t v;
    v.rst = r; v.rdy = rd; v.din = din; v.endi = endi;
    v.nmi_n = nmi_n; v.irq_n = irq_n; v.iflag = iflag;
    v.e_t = e_t; v.e_op = e_op; v.e_prev = e_prev; v.e_act = e_act;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, got, want);
    end
  endtask

  task automatic tick();
    @(posedge phi2);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b1; bus.dataIn = 8'h00; bus.endInstr = 1'b0;
    bus.nmi_n = 1'b1; bus.irq_n = 1'b1; bus.iFlag = 1'b1;

    //   rst rdy din    end nmi irq iF   T      OP     prev   act
    add(1, 1, 8'hA9, 0, 1, 1, 1,  7'h01, 8'hEA, 8'hEA, 3'b000); // 0 reset
    add(0, 1, 8'hA9, 0, 1, 1, 1,  7'h02, 8'h00, 8'hEA, 3'b100); // 1 reset BRK
    add(0, 1, 8'hA9, 0, 1, 1, 1,  7'h04, 8'h00, 8'hEA, 3'b100);
    add(0, 1, 8'hA9, 0, 1, 1, 1,  7'h08, 8'h00, 8'hEA, 3'b100);
    add(0, 1, 8'hA9, 0, 1, 1, 1,  7'h10, 8'h00, 8'hEA, 3'b100);
    add(0, 1, 8'hA9, 0, 1, 1, 1,  7'h20, 8'h00, 8'hEA, 3'b100);
    add(0, 1, 8'hA9, 0, 1, 1, 1,  7'h40, 8'h00, 8'hEA, 3'b100); // 6 T7
    add(0, 1, 8'hA9, 1, 1, 1, 1,  7'h01, 8'h00, 8'hEA, 3'b100); // 7 end at T7
    add(0, 1, 8'hA9, 0, 1, 1, 1,  7'h02, 8'hA9, 8'h00, 3'b000); // 8 fetch A9
    add(0, 1, 8'hA9, 1, 1, 1, 1,  7'h01, 8'hA9, 8'h00, 3'b000); // 9 2-cycle
    add(0, 1, 8'h20, 0, 1, 1, 1,  7'h02, 8'h20, 8'hA9, 3'b000); // 10
    add(0, 1, 8'h20, 0, 1, 1, 1,  7'h04, 8'h20, 8'hA9, 3'b000);
    add(0, 1, 8'h20, 0, 1, 1, 1,  7'h08, 8'h20, 8'hA9, 3'b000);
    add(0, 1, 8'h20, 1, 1, 1, 1,  7'h01, 8'h20, 8'hA9, 3'b000); // 13 4-cycle done
    add(0, 1, 8'h4C, 0, 1, 1, 1,  7'h02, 8'h4C, 8'h20, 3'b000); // 14
    add(0, 1, 8'h4C, 0, 1, 1, 1,  7'h04, 8'h4C, 8'h20, 3'b000);
    add(0, 1, 8'h4C, 0, 0, 0, 0,  7'h08, 8'h4C, 8'h20, 3'b000); // 16 NMI edge in T3, IRQ low
    add(0, 1, 8'h4C, 1, 0, 0, 0,  7'h01, 8'h4C, 8'h20, 3'b000);
    add(0, 1, 8'h55, 0, 0, 0, 0,  7'h02, 8'h00, 8'h4C, 3'b010); // 18 NMI beats IRQ
    add(0, 1, 8'h55, 1, 0, 0, 0,  7'h01, 8'h00, 8'h4C, 3'b010);
    add(0, 1, 8'h55, 0, 0, 0, 0,  7'h02, 8'h00, 8'h00, 3'b001); // 20 IRQ next
    add(0, 1, 8'h55, 1, 1, 1, 0,  7'h01, 8'h00, 8'h00, 3'b001);
    add(0, 1, 8'h69, 0, 1, 0, 1,  7'h02, 8'h69, 8'h00, 3'b000); // 22 IRQ masked
    add(0, 1, 8'h69, 1, 1, 0, 1,  7'h01, 8'h69, 8'h00, 3'b000);
    add(0, 1, 8'h69, 0, 1, 0, 0,  7'h02, 8'h00, 8'h69, 3'b001); // 24 unmasked
    add(0, 1, 8'h69, 0, 1, 1, 1,  7'h04, 8'h00, 8'h69, 3'b001);
    add(0, 0, 8'hFF, 1, 0, 1, 1,  7'h04, 8'h00, 8'h69, 3'b001); // 26 stall, NMI edge
    add(0, 0, 8'hFF, 1, 0, 1, 1,  7'h04, 8'h00, 8'h69, 3'b001);
    add(0, 0, 8'hFF, 1, 1, 1, 1,  7'h04, 8'h00, 8'h69, 3'b001);
    add(0, 1, 8'h77, 1, 1, 1, 1,  7'h01, 8'h00, 8'h69, 3'b001); // 29
    add(0, 1, 8'h77, 0, 1, 1, 1,  7'h02, 8'h00, 8'h00, 3'b010); // 30 latched NMI taken
    add(0, 1, 8'h77, 1, 1, 1, 1,  7'h01, 8'h00, 8'h00, 3'b010);
    add(0, 1, 8'h77, 0, 1, 1, 1,  7'h02, 8'h77, 8'h00, 3'b000); // 32 no duplicate
    add(0, 1, 8'h88, 1, 1, 1, 1,  7'h01, 8'h77, 8'h00, 3'b000);
    add(0, 1, 8'h88, 0, 0, 1, 1,  7'h02, 8'h00, 8'h77, 3'b010); // 34 edge in Tone
    add(0, 1, 8'h88, 1, 0, 1, 1,  7'h01, 8'h00, 8'h77, 3'b010);
    add(0, 1, 8'h88, 0, 0, 1, 1,  7'h02, 8'h88, 8'h00, 3'b000); // 36 consumed once
    add(0, 1, 8'h88, 0, 1, 1, 1,  7'h04, 8'h88, 8'h00, 3'b000);
    add(1, 0, 8'h88, 1, 1, 1, 1,  7'h01, 8'hEA, 8'hEA, 3'b000); // 38 rst mid-instr
    add(0, 1, 8'hA9, 0, 1, 1, 1,  7'h02, 8'h00, 8'hEA, 3'b100); // 39
    add(0, 1, 8'hA9, 1, 1, 1, 1,  7'h01, 8'h00, 8'hEA, 3'b100);
    add(0, 1, 8'h11, 0, 1, 1, 1,  7'h02, 8'h11, 8'h00, 3'b000); // 41
    add(0, 1, 8'h11, 0, 1, 0, 0,  7'h04, 8'h11, 8'h00, 3'b000); // 42 IRQ pulse
    add(0, 1, 8'h11, 1, 1, 1, 0,  7'h01, 8'h11, 8'h00, 3'b000);
    add(0, 1, 8'h22, 0, 1, 1, 0,  7'h02, 8'h22, 8'h11, 3'b000); // 44 not taken
    add(0, 1, 8'h22, 1, 1, 1, 0,  7'h01, 8'h22, 8'h11, 3'b000);

    for (int i = 0; i < vq.size(); i++) begin
      rst          = vq[i].rst;
      bus.rdy      = vq[i].rdy;
      bus.dataIn   = vq[i].din;
      bus.endInstr = vq[i].endi;
      bus.nmi_n    = vq[i].nmi_n;
      bus.irq_n    = vq[i].irq_n;
      bus.iFlag    = vq[i].iflag;
      tick();
      chk("T", i, {1'b0, bus.T}, {1'b0, vq[i].e_t});
      chk("OP", i, bus.OP, vq[i].e_op);
      chk("prevOP", i, bus.prevOP, vq[i].e_prev);
      chk("activeInt", i, {5'd0, bus.activeInt}, {5'd0, vq[i].e_act});
      chk("sync", i, {7'd0, bus.sync}, {7'd0, (vq[i].e_t == 7'h01)});
      chk("seqErr", i, {7'd0, bus.seqErr}, 8'h00);
    end

    // Overrun: endInstr held low from Tone walks T through Tseven and back.
    rst = 1'b0; bus.rdy = 1'b1; bus.dataIn = 8'h33; bus.endInstr = 1'b0;
    bus.nmi_n = 1'b1; bus.irq_n = 1'b1; bus.iFlag = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [6:0] exp_t;
      exp_t = 7'h02 << i;
      tick();
      chk("ovr_T", 100 + i, {1'b0, bus.T}, {1'b0, exp_t});
      chk("ovr_seqErr", 100 + i, {7'd0, bus.seqErr}, 8'h00);
    end
    tick();
    chk("ovr_T", 106, {1'b0, bus.T}, 8'h01);
    chk("ovr_seqErr", 106, {7'd0, bus.seqErr}, 8'h01);
    tick();
    chk("sticky_T", 107, {1'b0, bus.T}, 8'h02);
    chk("sticky_seqErr", 107, {7'd0, bus.seqErr}, 8'h01);
    bus.endInstr = 1'b1;
    tick();
    chk("sticky_seqErr", 108, {7'd0, bus.seqErr}, 8'h01);
    rst = 1'b1;
    tick();
    chk("rst_seqErr", 109, {7'd0, bus.seqErr}, 8'h00);
    chk("rst_T", 109, {1'b0, bus.T}, 8'h01);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
